mpu_ldst_ctrl: RTL and testbench
================================

# mpu_ldst_ctrl

Load/store sequencer for the matrix processor's single memory-side port. Accepts load and store requests from the memory/testbench side, checks dimensions, and sequences element-by-element transfers into and out of the matrix register file with row-major location counters. Arbitrates between simultaneous load and store requests. Sits between the MPU memory interface and the matrix register file.

## Interface
- M, 6, max matrix rows (global_defs)
- N, 6, max matrix columns (global_defs)
- MBITS, 2, row-size/index MSB; sizes are [MBITS:0]
- NBITS, 2, column-size/index MSB; sizes are [NBITS:0]
- MATRIX_REG_BITS, 3, register-address MSB
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- load_req, store_req  in  1  transfer requests, held until transfer ends
- mem_m_load_size / mem_n_load_size  in  MBITS+1 / NBITS+1  load dimensions
- mem_load_addr, mem_store_addr  in  MATRIX_REG_BITS+1  target/source register
- mem_load_element  in  32 (float_sp)  incoming element
- load_ready, store_ready  out  1  controller idle, request will be accepted
- mem_load_ack  out  1  high while load elements are consumed
- mem_load_error  out  1  one-cycle pulse on invalid load size
- reg_load_en  out  1  register-file write strobe
- reg_load_addr  out  MATRIX_REG_BITS+1; reg_m_load_size/reg_n_load_size  out; reg_i_load_loc/reg_j_load_loc  out  write location
- reg_load_element  out  32  write data
- reg_store_addr  out  MATRIX_REG_BITS+1; reg_store_en  out  1  read strobe; reg_i_store_loc/reg_j_store_loc  out
- reg_m_store_size / reg_n_store_size  in  size of addressed register (combinational on reg_store_addr)
- reg_store_element  in  32  read data, one cycle after reg_store_en
- mem_store_en  out  1; mem_store_element  out  32; mem_m_store_size / mem_n_store_size  out

## Operation
- States: IDLE, LD_XFER, ST_SIZE, ST_XFER, ST_DRAIN, RELEASE.
- IDLE: load_ready = store_ready = 1. Both requests high: serve the one not served last (priority bit, reset = load first); bit toggles on each grant.
- Load grant: latch sizes/addr. Size invalid (m=0, n=0, m>M, n>N) -> mem_load_error for 1 cycle, go RELEASE, no writes. Else LD_XFER.
- LD_XFER: mem_load_ack high exactly m*n cycles. Each edge with ack high samples mem_load_element; next cycle reg_load_en=1 with that element and its (i,j). Locations row-major: j increments, wraps at n-1 to 0 with i+1. After m*n samples -> RELEASE.
- Store grant: ST_SIZE drives reg_store_addr one cycle, latches reg_m/n_store_size onto mem_m/n_store_size. Size 0 in either dimension -> RELEASE, no mem_store_en. Else ST_XFER.
- ST_XFER: reg_store_en high m*n cycles stepping (i,j) row-major. mem_store_en = reg_store_en delayed one cycle; mem_store_element = reg_store_element (pass-through). ST_DRAIN covers the final data cycle, then RELEASE.
- RELEASE: stay until the served request is low, then IDLE (no re-trigger on a held request).
- Requests are ignored outside IDLE; a deasserted request mid-transfer does not abort it.

## Timing
- Reset: state IDLE, priority=load, all outputs 0 except load_ready=store_ready=1, all counters 0.
- Load: grant edge -> ack high next cycle; first reg_load_en one cycle after first ack; last reg_load_en one cycle after ack falls.
- Store: grant -> ST_SIZE (1 cycle) -> reg_store_en m*n cycles -> mem_store_en m*n cycles, lagging by 1.
- Transfer count register width $clog2(M*N)+1; m*n computed once at grant.
- Reset asserted mid-transfer: immediate return to reset values; partial register writes are not undone.

## Structure
- global_defs: M, N, MBITS, NBITS, MATRIX_REG_BITS. mpu_data_types: float_sp, mpu_ldst_state_t enum.
- Sub-module mpu_loc_counter: row-major (i,j) counter with clear, step, size inputs and last flag; instantiated once for load, once for store.

## Test plan
- Load 2x3 to addr 1, elements 1.0..6.0 -> ack high 6 cycles; reg_load_en writes (0,0)=1.0 ... (1,2)=6.0 to addr 1.
- Load size 7x2 and 0x3 -> mem_load_error one pulse each, zero reg_load_en, return to IDLE after load_req drops.
- Store 3x3 from addr 2 -> reg_store_en 9 cycles, mem_store_en 9 cycles one later, elements in row-major order, mem_m/n_store_size=3/3.
- Load and store asserted same cycle twice in a row -> load first, store second; next simultaneous pair -> store first.
- Held load_req after completion -> no second transfer until dropped and reasserted.
- rst low during 6x6 load at element 10 -> all outputs reset within the cycle, next load runs cleanly from (0,0).

Source files
------------

// File: rtl/mpu_ldst_ctrl_pkg.sv
// Purpose: shared dimensions, data types and FSM encodings for the MPU load/store sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mpu_ldst_ctrl_pkg;

    // global_defs
    localparam int M               = 6;
    localparam int N               = 6;
    localparam int MBITS           = 2;
    localparam int NBITS           = 2;
    localparam int MATRIX_REG_BITS = 3;

    // Element counter must hold m*n for the largest size the fields can encode (7x7).
    localparam int CNT_W = $clog2(M * N) + 1;

    // mpu_data_types
    typedef logic [31:0] float_sp;
    typedef logic [2:0]  mpu_ldst_state_t;

    localparam mpu_ldst_state_t IDLE     = 3'd0;
    localparam mpu_ldst_state_t LD_XFER  = 3'd1;
    localparam mpu_ldst_state_t ST_SIZE  = 3'd2;
    localparam mpu_ldst_state_t ST_XFER  = 3'd3;
    localparam mpu_ldst_state_t ST_DRAIN = 3'd4;
    localparam mpu_ldst_state_t RELEASE  = 3'd5;

    function automatic logic [CNT_W-1:0] xfer_count(input logic [MBITS:0] m, input logic [NBITS:0] n);
        return CNT_W'(m) * CNT_W'(n);
    endfunction

    function automatic logic load_size_ok(input logic [MBITS:0] m, input logic [NBITS:0] n);
        return (m != '0) && (n != '0) && (m <= (MBITS+1)'(M)) && (n <= (NBITS+1)'(N));
    endfunction

endpackage

// File: rtl/mpu_loc_counter.sv
// Purpose: row-major (i,j) location counter; j runs fastest and wraps to 0 with i+1.
// Latency: location updates on the edge after step; last is combinational on the current location.
// Backpressure: none; advances only when step is high, clear has priority over step.
// Ports: clk, rst (async active-low), clear, step, m_size/n_size (matrix dims),
//        i/j (current location), last (location is (m-1,n-1)).
module mpu_loc_counter
    import mpu_ldst_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    input  logic [MBITS:0]   m_size,
    input  logic [NBITS:0]   n_size,
    output logic [MBITS:0]   i,
    output logic [NBITS:0]   j,
    output logic             last
);

    logic j_wrap;

    assign j_wrap = (j == n_size - (NBITS+1)'(1));
    assign last   = j_wrap && (i == m_size - (MBITS+1)'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i <= '0;
            j <= '0;
        end else if (clear) begin
            i <= '0;
            j <= '0;
        end else if (step) begin
            if (j_wrap) begin
                j <= '0;
                i <= last ? '0 : i + (MBITS+1)'(1);
            end else begin
                j <= j + (NBITS+1)'(1);
            end
        end
    end

endmodule

// File: rtl/mpu_ldst_ctrl.sv
// Purpose: sequences load/store element transfers between the MPU memory port and the matrix register file.
// Latency: load ack 1 cycle after grant, each write 1 cycle after its sample; store reads 2 cycles after grant, memory side lags reads by 1.
// Backpressure: none inside a transfer; requests are only accepted in IDLE (load_ready/store_ready) and must drop before the next grant.
// Ports: clk, rst (async active-low); load_req/store_req with load dims, addresses and element from memory;
//        load_ready/store_ready, mem_load_ack, mem_load_error; register-file write port (reg_load_*),
//        register-file read port (reg_store_*), memory store port (mem_store_*).
module mpu_ldst_ctrl
    import mpu_ldst_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_req,
    input  logic                       store_req,
    input  logic [MBITS:0]             mem_m_load_size,
    input  logic [NBITS:0]             mem_n_load_size,
    input  logic [MATRIX_REG_BITS:0]   mem_load_addr,
    input  logic [MATRIX_REG_BITS:0]   mem_store_addr,
    input  logic [31:0]                mem_load_element,
    output logic                       load_ready,
    output logic                       store_ready,
    output logic                       mem_load_ack,
    output logic                       mem_load_error,
    output logic                       reg_load_en,
    output logic [MATRIX_REG_BITS:0]   reg_load_addr,
    output logic [MBITS:0]             reg_m_load_size,
    output logic [NBITS:0]             reg_n_load_size,
    output logic [MBITS:0]             reg_i_load_loc,
    output logic [NBITS:0]             reg_j_load_loc,
    output logic [31:0]                reg_load_element,
    output logic [MATRIX_REG_BITS:0]   reg_store_addr,
    output logic                       reg_store_en,
    output logic [MBITS:0]             reg_i_store_loc,
    output logic [NBITS:0]             reg_j_store_loc,
    input  logic [MBITS:0]             reg_m_store_size,
    input  logic [NBITS:0]             reg_n_store_size,
    input  logic [31:0]                reg_store_element,
    output logic                       mem_store_en,
    output logic [31:0]                mem_store_element,
    output logic [MBITS:0]             mem_m_store_size,
    output logic [NBITS:0]             mem_n_store_size
);

    mpu_ldst_state_t   state;
    logic              prio_store;   // 1: store wins the next contended request
    logic              served_load;  // which request RELEASE waits on
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  total;
    logic              grant_load;
    logic              grant_store;
    logic              cnt_done;
    logic              ld_last;
    logic              st_last;
    logic [MBITS:0]    ld_i;
    logic [NBITS:0]    ld_j;

    assign load_ready        = (state == IDLE);
    assign store_ready       = (state == IDLE);
    assign mem_load_ack      = (state == LD_XFER);
    assign reg_store_en      = (state == ST_XFER);
    assign mem_store_element = reg_store_element;

    assign grant_load  = (state == IDLE) && load_req && (!store_req || !prio_store);
    assign grant_store = (state == IDLE) && store_req && !grant_load;

    // Element count and location counter must agree on the final element.
    assign cnt_done = (cnt == total - CNT_W'(1));

    mpu_loc_counter u_ld_loc (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == IDLE),
        .step   (mem_load_ack),
        .m_size (reg_m_load_size),
        .n_size (reg_n_load_size),
        .i      (ld_i),
        .j      (ld_j),
        .last   (ld_last)
    );

    mpu_loc_counter u_st_loc (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == IDLE),
        .step   (reg_store_en),
        .m_size (mem_m_store_size),
        .n_size (mem_n_store_size),
        .i      (reg_i_store_loc),
        .j      (reg_j_store_loc),
        .last   (st_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            prio_store       <= 1'b0;
            served_load      <= 1'b0;
            cnt              <= '0;
            total            <= '0;
            mem_load_error   <= 1'b0;
            reg_load_en      <= 1'b0;
            reg_load_addr    <= '0;
            reg_m_load_size  <= '0;
            reg_n_load_size  <= '0;
            reg_i_load_loc   <= '0;
            reg_j_load_loc   <= '0;
            reg_load_element <= '0;
            reg_store_addr   <= '0;
            mem_store_en     <= 1'b0;
            mem_m_store_size <= '0;
            mem_n_store_size <= '0;
        end else begin
            reg_load_en    <= 1'b0;
            mem_load_error <= 1'b0;
            mem_store_en   <= reg_store_en;
            case (state)
                IDLE: begin
                    // Priority only moves when both requests compete, so a lone
                    // request does not steal the other side's turn.
                    if (load_req && store_req) begin
                        prio_store <= !prio_store;
                    end
                    cnt <= '0;
                    if (grant_load) begin
                        served_load     <= 1'b1;
                        reg_load_addr   <= mem_load_addr;
                        reg_m_load_size <= mem_m_load_size;
                        reg_n_load_size <= mem_n_load_size;
                        total           <= xfer_count(mem_m_load_size, mem_n_load_size);
                        if (load_size_ok(mem_m_load_size, mem_n_load_size)) begin
                            state <= LD_XFER;
                        end else begin
                            mem_load_error <= 1'b1;
                            state          <= RELEASE;
                        end
                    end else if (grant_store) begin
                        served_load    <= 1'b0;
                        reg_store_addr <= mem_store_addr;
                        state          <= ST_SIZE;
                    end
                end
                LD_XFER: begin
                    reg_load_en      <= 1'b1;
                    reg_load_element <= mem_load_element;
                    reg_i_load_loc   <= ld_i;
                    reg_j_load_loc   <= ld_j;
                    cnt              <= cnt + CNT_W'(1);
                    if (cnt_done && ld_last) begin
                        state <= RELEASE;
                    end
                end
                ST_SIZE: begin
                    mem_m_store_size <= reg_m_store_size;
                    mem_n_store_size <= reg_n_store_size;
                    total            <= xfer_count(reg_m_store_size, reg_n_store_size);
                    if ((reg_m_store_size == '0) || (reg_n_store_size == '0)) begin
                        state <= RELEASE;
                    end else begin
                        state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt_done && st_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Last read data is on the bus this cycle.
                    state <= RELEASE;
                end
                RELEASE: begin
                    if (served_load ? !load_req : !store_req) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_ldst_ctrl.sv
// Purpose: scoreboard bench for mpu_ldst_ctrl with a register-file read model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mpu_ldst_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_req, store_req;
    logic [2:0]  mem_m_load_size, mem_n_load_size;
    logic [3:0]  mem_load_addr, mem_store_addr;
    logic [31:0] mem_load_element;
    logic        load_ready, store_ready, mem_load_ack, mem_load_error;
    logic        reg_load_en;
    logic [3:0]  reg_load_addr;
    logic [2:0]  reg_m_load_size, reg_n_load_size, reg_i_load_loc, reg_j_load_loc;
    logic [31:0] reg_load_element;
    logic [3:0]  reg_store_addr;
    logic        reg_store_en;
    logic [2:0]  reg_i_store_loc, reg_j_store_loc;
    logic [2:0]  reg_m_store_size, reg_n_store_size;
    logic [31:0] reg_store_element;
    logic        mem_store_en;
    logic [31:0] mem_store_element;
    logic [2:0]  mem_m_store_size, mem_n_store_size;

    always #5 clk = ~clk;

    mpu_ldst_ctrl dut (
        .clk(clk), .rst(rst),
        .load_req(load_req), .store_req(store_req),
        .mem_m_load_size(mem_m_load_size), .mem_n_load_size(mem_n_load_size),
        .mem_load_addr(mem_load_addr), .mem_store_addr(mem_store_addr),
        .mem_load_element(mem_load_element),
        .load_ready(load_ready), .store_ready(store_ready),
        .mem_load_ack(mem_load_ack), .mem_load_error(mem_load_error),
        .reg_load_en(reg_load_en), .reg_load_addr(reg_load_addr),
        .reg_m_load_size(reg_m_load_size), .reg_n_load_size(reg_n_load_size),
        .reg_i_load_loc(reg_i_load_loc), .reg_j_load_loc(reg_j_load_loc),
        .reg_load_element(reg_load_element),
        .reg_store_addr(reg_store_addr), .reg_store_en(reg_store_en),
        .reg_i_store_loc(reg_i_store_loc), .reg_j_store_loc(reg_j_store_loc),
        .reg_m_store_size(reg_m_store_size), .reg_n_store_size(reg_n_store_size),
        .reg_store_element(reg_store_element),
        .mem_store_en(mem_store_en), .mem_store_element(mem_store_element),
        .mem_m_store_size(mem_m_store_size), .mem_n_store_size(mem_n_store_size)
    );

    typedef struct packed {
        logic [3:0]  addr;
        logic [2:0]  i;
        logic [2:0]  j;
        logic [31:0] d;
        logic [2:0]  m;
        logic [2:0]  n;
    } ld_exp_t;

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  m;
        logic [2:0]  n;
    } st_exp_t;

    ld_exp_t exp_ld[$];
    st_exp_t exp_st[$];
    byte     exp_gnt[$];

    int tests = 0;
    int fails = 0;
    int ack_cnt = 0, err_cnt = 0, sen_cnt = 0, men_cnt = 0;
    int ld_k;

    logic [31:0] elem_tab [36];
    logic [2:0]  sz_m [16];
    logic [2:0]  sz_n [16];

    // Memory side: element k of the current load is presented until the k-th ack edge.
    always @(posedge clk) begin
        if (!rst || !load_req) ld_k <= 0;
        else if (mem_load_ack) ld_k <= ld_k + 1;
    end
    assign mem_load_element = elem_tab[ld_k % 36];

    // Register-file read model: sizes combinational on address, data one cycle after the strobe.
    function automatic logic [31:0] st_val(input logic [3:0] a, input logic [2:0] i, input logic [2:0] j);
        return {16'h5000, a, 1'b0, i, 1'b0, j, 4'h0};
    endfunction
    assign reg_m_store_size = sz_m[reg_store_addr];
    assign reg_n_store_size = sz_n[reg_store_addr];
    always @(posedge clk) begin
        if (reg_store_en) reg_store_element <= st_val(reg_store_addr, reg_i_store_loc, reg_j_store_loc);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a write, a store beat or a grant.
    logic prev_ack = 1'b0, prev_sen = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            if (reg_load_en) begin
                if (exp_ld.size() == 0) chk("ld_write_extra", 64'(reg_load_element), 64'hDEAD);
                else chk("ld_write", 64'({reg_load_addr, reg_i_load_loc, reg_j_load_loc,
                                          reg_load_element, reg_m_load_size, reg_n_load_size}),
                         64'(exp_ld.pop_front()));
            end
            if (mem_store_en) begin
                if (exp_st.size() == 0) chk("st_beat_extra", 64'(mem_store_element), 64'hDEAD);
                else chk("st_beat", 64'({mem_store_element, mem_m_store_size, mem_n_store_size}),
                         64'(exp_st.pop_front()));
            end
            if (mem_load_ack && !prev_ack) begin
                if (exp_gnt.size() == 0) chk("grant_extra_L", 64'd76, 64'd0);
                else chk("grant_order", 64'd76, 64'(exp_gnt.pop_front()));
            end
            if (reg_store_en && !prev_sen) begin
                if (exp_gnt.size() == 0) chk("grant_extra_S", 64'd83, 64'd0);
                else chk("grant_order", 64'd83, 64'(exp_gnt.pop_front()));
            end
            if (mem_load_ack) ack_cnt++;
            if (mem_load_error) err_cnt++;
            if (reg_store_en) sen_cnt++;
            if (mem_store_en) men_cnt++;
        end
        prev_ack = rst && mem_load_ack;
        prev_sen = rst && reg_store_en;
    end

    task automatic push_ld(input int m, input int n, input logic [3:0] addr, input int count);
        for (int k = 0; k < count; k++)
            exp_ld.push_back('{addr, 3'(k / n), 3'(k % n), elem_tab[k], 3'(m), 3'(n)});
    endtask

    task automatic push_st(input logic [3:0] addr);
        for (int i = 0; i < int'(sz_m[addr]); i++)
            for (int j = 0; j < int'(sz_n[addr]); j++)
                exp_st.push_back('{st_val(addr, 3'(i), 3'(j)), sz_m[addr], sz_n[addr]});
    endtask

    task automatic set_load(input int m, input int n, input logic [3:0] addr);
        mem_m_load_size = 3'(m);
        mem_n_load_size = 3'(n);
        mem_load_addr   = addr;
    endtask

    task automatic wait_ld_done();
        for (int c = 0; c < 300 && !(exp_ld.size() == 0 && !mem_load_ack); c++) tick();
        chk("ld_done_timeout", 64'(exp_ld.size() == 0 && !mem_load_ack), 64'd1);
    endtask

    task automatic wait_st_done();
        for (int c = 0; c < 300 && exp_st.size() != 0; c++) tick();
        chk("st_done_timeout", 64'(exp_st.size()), 64'd0);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 20 && !(load_ready && store_ready); c++) tick();
        chk("return_idle", 64'({load_ready, store_ready}), 64'd3);
    endtask

    task automatic do_load(input int m, input int n, input logic [3:0] addr, input bit valid);
        int a0, e0;
        a0 = ack_cnt;
        e0 = err_cnt;
        if (valid) begin
            push_ld(m, n, addr, m * n);
            exp_gnt.push_back(8'd76);
        end
        set_load(m, n, addr);
        load_req = 1'b1;
        tick();
        chk("ld_accepted", 64'(load_ready), 64'd0);
        wait_ld_done();
        // Request is still held here: no second transfer may start.
        repeat (4) tick();
        chk("ld_ack_cycles", 64'(ack_cnt - a0), valid ? 64'(m * n) : 64'd0);
        chk("ld_error_pulses", 64'(err_cnt - e0), valid ? 64'd0 : 64'd1);
        chk("ld_held_no_idle", 64'(load_ready), 64'd0);
        load_req = 1'b0;
        wait_idle();
    endtask

    task automatic do_store(input logic [3:0] addr);
        int s0, m0, cnt;
        s0  = sen_cnt;
        m0  = men_cnt;
        cnt = int'(sz_m[addr]) * int'(sz_n[addr]);
        push_st(addr);
        if (cnt > 0) exp_gnt.push_back(8'd83);
        mem_store_addr = addr;
        store_req = 1'b1;
        tick();
        chk("st_accepted", 64'(store_ready), 64'd0);
        wait_st_done();
        repeat (3) tick();
        chk("st_read_cycles", 64'(sen_cnt - s0), 64'(cnt));
        chk("st_write_cycles", 64'(men_cnt - m0), 64'(cnt));
        chk("st_sizes", 64'({mem_m_store_size, mem_n_store_size}), 64'({sz_m[addr], sz_n[addr]}));
        store_req = 1'b0;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d", tests);
        $fatal(1);
    end

    initial begin
        elem_tab[0] = 32'h3F80_0000;  // 1.0
        elem_tab[1] = 32'h4000_0000;  // 2.0
        elem_tab[2] = 32'h4040_0000;  // 3.0
        elem_tab[3] = 32'h4080_0000;  // 4.0
        elem_tab[4] = 32'h40A0_0000;  // 5.0
        elem_tab[5] = 32'h40C0_0000;  // 6.0
        for (int k = 6; k < 36; k++) elem_tab[k] = 32'hC000_0000 + 32'(k);
        for (int a = 0; a < 16; a++) begin
            sz_m[a] = 3'd0;
            sz_n[a] = 3'd0;
        end
        sz_m[2] = 3'd3; sz_n[2] = 3'd3;
        sz_m[3] = 3'd0; sz_n[3] = 3'd2;

        rst = 1'b0;
        load_req = 1'b0;
        store_req = 1'b0;
        set_load(0, 0, 4'd0);
        mem_store_addr = 4'd0;
        repeat (2) tick();
        chk("rst_ready", 64'({load_ready, store_ready}), 64'd3);
        chk("rst_strobes", 64'({mem_load_ack, mem_load_error, reg_load_en, reg_store_en, mem_store_en}), 64'd0);
        chk("rst_load_outs", 64'({reg_load_addr, reg_i_load_loc, reg_j_load_loc, reg_m_load_size, reg_n_load_size}), 64'd0);
        chk("rst_store_outs", 64'({reg_store_addr, mem_m_store_size, mem_n_store_size}), 64'd0);
        rst = 1'b1;
        tick();

        // 2x3 load of 1.0..6.0 into register 1
        do_load(2, 3, 4'd1, 1'b1);
        // invalid sizes: too many rows, zero rows
        do_load(7, 2, 4'd5, 1'b0);
        do_load(0, 3, 4'd5, 1'b0);
        // 3x3 store from register 2, then a zero-sized register
        do_store(4'd2);
        do_store(4'd3);

        // Contended requests: load wins first, then store wins the next contention.
        exp_gnt.push_back(8'd76);
        exp_gnt.push_back(8'd83);
        push_ld(2, 2, 4'd4, 4);
        push_st(4'd2);
        set_load(2, 2, 4'd4);
        mem_store_addr = 4'd2;
        load_req = 1'b1;
        store_req = 1'b1;
        wait_ld_done();
        repeat (2) tick();
        load_req = 1'b0;
        wait_st_done();
        repeat (3) tick();
        store_req = 1'b0;
        wait_idle();

        exp_gnt.push_back(8'd83);
        exp_gnt.push_back(8'd76);
        push_st(4'd2);
        push_ld(2, 2, 4'd4, 4);
        load_req = 1'b1;
        store_req = 1'b1;
        wait_st_done();
        repeat (3) tick();
        store_req = 1'b0;
        wait_ld_done();
        repeat (2) tick();
        load_req = 1'b0;
        wait_idle();
        chk("grants_all_seen", 64'(exp_gnt.size()), 64'd0);

        // Reset during a 6x6 load once 10 elements were sampled: only 9 writes reach the bus.
        exp_gnt.push_back(8'd76);
        push_ld(6, 6, 4'd6, 9);
        set_load(6, 6, 4'd6);
        load_req = 1'b1;
        for (int c = 0; c < 50 && ld_k != 10; c++) tick();
        chk("mid_reset_reached", 64'(ld_k), 64'd10);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", 64'({load_ready, store_ready}), 64'd3);
        chk("mid_rst_strobes", 64'({mem_load_ack, mem_load_error, reg_load_en, reg_store_en, mem_store_en}), 64'd0);
        chk("mid_rst_load_outs", 64'({reg_load_addr, reg_i_load_loc, reg_j_load_loc, reg_m_load_size, reg_n_load_size}), 64'd0);
        chk("mid_rst_writes", 64'(exp_ld.size()), 64'd0);
        load_req = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        do_load(2, 3, 4'd1, 1'b1);

        chk("queues_empty", 64'({32'(exp_ld.size()), 32'(exp_st.size() + exp_gnt.size())}), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
